// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: an instruction-fetch port and a data port share one fixed-latency memory.
// Data accesses win ties, except that a fetch pending through STARVE_LIMIT data grants wins the next one.
module mem_arbiter #(
  parameter int unsigned MEM_LATENCY  = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        stall
);

  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] starve_q, starve_d;
  logic [CW-1:0] lat_q, lat_d;
  logic          win_if_q, win_if_d;
  logic          we_q, we_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic [31:0]   dm_rdata_q, dm_rdata_d;
  logic          if_ready_q, if_ready_d;
  logic          dm_ready_q, dm_ready_d;
  logic          grant_if;

  // Fetch wins when alone, or when it has waited out STARVE_LIMIT data grants.
  assign grant_if = if_req & (~dm_req | (starve_q == CW'(STARVE_LIMIT)));

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    lat_d       = lat_q;
    win_if_d    = win_if_q;
    we_d        = we_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ready_d  = 1'b0;
    dm_ready_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (if_req | dm_req) begin
          state_d  = ISSUE;
          win_if_d = grant_if;
          mem_en_d = 1'b1;
          if (grant_if) begin
            we_d        = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = 32'h0;
            starve_d    = '0;
          end else begin
            we_d        = dm_we;
            mem_we_d    = dm_we;
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_wdata;
            if (!if_req) begin
              starve_d = '0;
            end else if (starve_q != CW'(STARVE_LIMIT)) begin
              starve_d = starve_q + CW'(1);
            end
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
        lat_d   = CW'(MEM_LATENCY - 1);
      end
      WAIT: begin
        if (lat_q == '0) begin
          state_d = RESP;
          if (win_if_q) begin
            if_rdata_d = mem_rdata;
            if_ready_d = 1'b1;
          end else begin
            if (!we_q) dm_rdata_d = mem_rdata;
            dm_ready_d = 1'b1;
          end
        end else begin
          lat_d = lat_q - CW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset drops any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      lat_q       <= '0;
      win_if_q    <= 1'b0;
      we_q        <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      if_rdata_q  <= 32'h0;
      dm_rdata_q  <= 32'h0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      lat_q       <= lat_d;
      win_if_q    <= win_if_d;
      we_q        <= we_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ready_q  <= if_ready_d;
      dm_ready_q  <= dm_ready_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_ready  = if_ready_q;
  assign dm_ready  = dm_ready_q;
  assign stall     = (if_req & ~if_ready_q) | (dm_req & ~dm_ready_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requesters push expected memory strobes and responses,
// monitors pop and compare whenever the DUT strobes memory or pulses a ready.
module tb_mem_arbiter;

  localparam int unsigned LAT = 2;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } mem_exp_t;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } resp_exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = 32'h0;
  logic [31:0] dm_wdata = 32'h0;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        stall;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          mon_on = 1'b0;
  bit          mem_chk = 1'b1;
  logic [31:0] last_dm = 32'h0;

  mem_exp_t    mem_q[$];
  resp_exp_t   if_q[$];
  resp_exp_t   dm_q[$];

  mem_arbiter #(.MEM_LATENCY(LAT), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall(stall)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory contents: upper half constant, lower half address + 1.
  function automatic logic [31:0] rd(input logic [31:0] a);
    return {16'h2002, a[15:0] + 16'h0001};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory model: read data valid exactly LAT cycles after the strobe, garbage otherwise.
  initial begin
    logic [31:0] pend_addr;
    int          pend_cyc;
    pend_addr = 32'h0;
    pend_cyc  = -1;
    forever begin
      @(negedge clk);
      if (mem_en === 1'b1) begin
        pend_addr = mem_addr;
        pend_cyc  = cyc + int'(LAT);
      end
      mem_rdata = (cyc == pend_cyc) ? rd(pend_addr) : 32'hBAD0_BAD0;
    end
  end

  // Monitor: pops the scoreboards on every strobe and ready.
  initial begin
    logic prev_en;
    prev_en = 1'b0;
    wait (mon_on);
    forever begin
      @(negedge clk);
      chk("both_ready", 32'(if_ready & dm_ready), 32'h0);
      chk("we_without_en", 32'(mem_we & ~mem_en), 32'h0);
      chk("en_back_to_back", 32'(mem_en & prev_en), 32'h0);
      prev_en = mem_en;
      if (mem_en && mem_chk) begin
        if (mem_q.size() == 0) begin
          chk("mem_unexpected", 32'(mem_en), 32'h0);
        end else begin
          mem_exp_t m;
          m = mem_q.pop_front();
          chk("mem_cycle", 32'(cyc), 32'(m.cyc));
          chk("mem_addr", mem_addr, m.addr);
          chk("mem_we", 32'(mem_we), 32'(m.we));
          if (m.we) chk("mem_wdata", mem_wdata, m.wdata);
        end
      end
      if (if_ready) begin
        if (if_q.size() == 0) begin
          chk("if_ready_unexpected", 32'(if_ready), 32'h0);
        end else begin
          resp_exp_t r;
          r = if_q.pop_front();
          chk("if_rdata", if_rdata, r.data);
          if (r.cyc >= 0) chk("if_ready_cycle", 32'(cyc), 32'(r.cyc));
        end
      end
      if (dm_ready) begin
        if (dm_q.size() == 0) begin
          chk("dm_ready_unexpected", 32'(dm_ready), 32'h0);
        end else begin
          resp_exp_t r;
          r = dm_q.pop_front();
          chk("dm_rdata", dm_rdata, r.data);
          if (r.cyc >= 0) chk("dm_ready_cycle", 32'(cyc), 32'(r.cyc));
        end
      end
    end
  end

  task automatic push_mem(input int c, input logic [31:0] a, input logic we, input logic [31:0] wd);
    mem_exp_t m;
    m.cyc = c; m.addr = a; m.we = we; m.wdata = wd;
    mem_q.push_back(m);
  endtask

  // Fetch requester: raise now, hold until ready, then drop.
  task automatic if_txn(input logic [31:0] a, input logic [31:0] exp, input int exp_cyc);
    resp_exp_t r;
    int n;
    r.data = exp; r.cyc = exp_cyc;
    if_q.push_back(r);
    if_req  = 1'b1;
    if_addr = a;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!if_ready && n < 60);
    chk("if_done", 32'(if_ready), 32'h1);
    if_req = 1'b0;
  endtask

  // Data requester; hold keeps dm_req high for an immediately following request.
  task automatic dm_txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp, input int exp_cyc, input bit hold);
    resp_exp_t r;
    int n;
    r.data = exp; r.cyc = exp_cyc;
    dm_q.push_back(r);
    dm_req   = 1'b1;
    dm_we    = we;
    dm_addr  = a;
    dm_wdata = wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dm_ready && n < 60);
    chk("dm_done", 32'(dm_ready), 32'h1);
    if (!hold) dm_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_mem_en", 32'(mem_en), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_dm_rdata", dm_rdata, 32'h0);
    chk("rst_if_ready", 32'(if_ready), 32'h0);
    chk("rst_dm_ready", 32'(dm_ready), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    rst = 1'b0;
    mon_on = 1'b1;
    repeat (2) @(negedge clk);

    // Fetch only, with stall window and held address
    t = cyc;
    push_mem(t + 1, 32'h4, 1'b0, 32'h0);
    fork
      if_txn(32'h4, 32'h2002_0005, t + 4);
      begin
        for (int k = 0; k <= 4; k++) begin
          #1;
          chk("fetch_stall", 32'(stall), (k < 4) ? 32'h1 : 32'h0);
          if (k == 2) begin
            chk("wait_mem_addr", mem_addr, 32'h4);
            chk("wait_mem_en", 32'(mem_en), 32'h0);
          end
          @(negedge clk);
        end
      end
    join
    repeat (3) @(negedge clk);

    // Simultaneous requests: data first
    t = cyc;
    push_mem(t + 1, 32'h10, 1'b0, 32'h0);
    push_mem(t + 6, 32'h8, 1'b0, 32'h0);
    fork
      dm_txn(1'b0, 32'h10, 32'h0, 32'h2002_0011, t + 4, 1'b0);
      if_txn(32'h8, 32'h2002_0009, t + 9);
    join
    repeat (3) @(negedge clk);

    // Store: dm_rdata keeps the previous load value
    t = cyc;
    push_mem(t + 1, 32'h10, 1'b1, 32'hDEAD_BEEF);
    dm_txn(1'b1, 32'h10, 32'hDEAD_BEEF, 32'h2002_0011, t + 4, 1'b0);
    repeat (3) @(negedge clk);

    // Starvation: DM, DM, DM, DM, IF, DM
    t = cyc;
    push_mem(t + 1,  32'h100, 1'b0, 32'h0);
    push_mem(t + 6,  32'h104, 1'b0, 32'h0);
    push_mem(t + 11, 32'h108, 1'b0, 32'h0);
    push_mem(t + 16, 32'h10C, 1'b0, 32'h0);
    push_mem(t + 21, 32'h40,  1'b0, 32'h0);
    push_mem(t + 26, 32'h110, 1'b0, 32'h0);
    fork
      begin
        dm_txn(1'b0, 32'h100, 32'h0, 32'h2002_0101, t + 4,  1'b1);
        dm_txn(1'b0, 32'h104, 32'h0, 32'h2002_0105, t + 9,  1'b1);
        dm_txn(1'b0, 32'h108, 32'h0, 32'h2002_0109, t + 14, 1'b1);
        dm_txn(1'b0, 32'h10C, 32'h0, 32'h2002_010D, t + 19, 1'b1);
        dm_txn(1'b0, 32'h110, 32'h0, 32'h2002_0111, t + 29, 1'b0);
      end
      if_txn(32'h40, 32'h2002_0041, t + 24);
    join
    repeat (3) @(negedge clk);

    // Reset during WAIT drops the access; the held request restarts at full latency
    t = cyc;
    push_mem(t + 1, 32'h20, 1'b0, 32'h0);
    if_req  = 1'b1;
    if_addr = 32'h20;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_dm = 32'h0;
    chk("wrst_mem_en", 32'(mem_en), 32'h0);
    chk("wrst_mem_addr", mem_addr, 32'h0);
    chk("wrst_if_rdata", if_rdata, 32'h0);
    chk("wrst_dm_rdata", dm_rdata, 32'h0);
    chk("wrst_if_ready", 32'(if_ready), 32'h0);
    push_mem(t + 4, 32'h20, 1'b0, 32'h0);
    if_txn(32'h20, 32'h2002_0021, t + 7);
    repeat (3) @(negedge clk);
    chk("mem_queue_empty", 32'(mem_q.size()), 32'h0);

    // Back-to-back traffic from both ports with random gaps
    mem_chk = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          logic [31:0] a;
          repeat ($urandom_range(0, 3)) @(negedge clk);
          a = $urandom & 32'h0000_FFFC;
          if_txn(a, rd(a), -1);
        end
      end
      begin
        for (int i = 0; i < 6; i++) begin
          logic        we;
          logic [31:0] a;
          logic [31:0] wd;
          logic [31:0] exp;
          repeat ($urandom_range(0, 2)) @(negedge clk);
          we  = 1'($urandom_range(0, 1));
          a   = $urandom & 32'h0000_FFFC;
          wd  = $urandom;
          exp = we ? last_dm : rd(a);
          dm_txn(we, a, wd, exp, -1, 1'b0);
          if (!we) last_dm = exp;
        end
      end
    join
    repeat (5) @(negedge clk);
    chk("if_queue_empty", 32'(if_q.size()), 32'h0);
    chk("dm_queue_empty", 32'(dm_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LATENCY, default 2: cycles from mem_en high to mem_rdata valid; legal range 1..15.
REQ-002 Parameter STARVE_LIMIT, default 4: maximum consecutive data-port grants while a fetch is pending; legal range 1..15.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous reset, active-high.
REQ-005 if_req  in  1  instruction-fetch request, held high until if_ready.
REQ-006 if_addr  in  32  fetch byte address.
REQ-007 if_rdata  out  32  fetched word.
REQ-008 if_ready  out  1  one-cycle fetch-completion pulse.
REQ-009 dm_req  in  1  data request, held high until dm_ready.
REQ-010 dm_we  in  1  1 = store, 0 = load.
REQ-011 dm_addr  in  32  data byte address.
REQ-012 dm_wdata  in  32  store data.
REQ-013 dm_rdata  out  32  load data.
REQ-014 dm_ready  out  1  one-cycle data-completion pulse.
REQ-015 mem_en  out  1  shared-memory access strobe.
REQ-016 mem_we  out  1  shared-memory write enable.
REQ-017 mem_addr  out  32  shared-memory address.
REQ-018 mem_wdata  out  32  shared-memory write data.
REQ-019 mem_rdata  in  32  shared-memory read data.
REQ-020 stall  out  1  pipeline stall request.

Function
REQ-021 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-022 IDLE: no request -> stay; any request -> latch winner, addr, we, wdata -> ISSUE.
REQ-023 Arbitration: data port wins when both requests are high, except when starve_cnt == STARVE_LIMIT, in which case fetch wins.
REQ-024 starve_cnt: +1 on a data grant with if_req high; cleared on a fetch grant or on a data grant with if_req low; saturates at STARVE_LIMIT.
REQ-025 ISSUE (exactly 1 cycle): mem_en=1, mem_addr/mem_we/mem_wdata = latched values -> WAIT.
REQ-026 WAIT (exactly MEM_LATENCY cycles): mem_en=0, mem_addr held; in the last WAIT cycle mem_rdata is captured into the winner's rdata register -> RESP.
REQ-027 RESP (1 cycle): winner's ready=1 -> IDLE; requests are not sampled in RESP.
REQ-028 Request-to-ready latency is MEM_LATENCY+2 cycles, measured from the IDLE cycle that samples the request.
REQ-029 Stores: mem_we=1 only in ISSUE; dm_rdata is not updated; dm_ready timing is identical to loads.
REQ-030 mem_we=0 whenever mem_en=0; the fetch port never asserts mem_we.
REQ-031 if_rdata/dm_rdata hold their last captured value until the next completion on the same port.
REQ-032 At most one ready is high in any cycle; ready never goes high while the FSM is outside RESP.
REQ-033 stall = (if_req & ~if_ready) | (dm_req & ~dm_ready), combinational.
REQ-034 Addresses pass through unchanged, with no alignment check.
REQ-035 A request dropped before its ready still completes: the latched transaction runs to RESP.

Reset
REQ-036 rst high at a clock edge -> state IDLE, starve_cnt=0, and all outputs 0 (mem_*, if_rdata, dm_rdata, ready signals) in the following cycle, from any state.
REQ-037 Reset mid-transaction drops the access: no ready pulse is produced and no further mem_en is issued for it.
REQ-038 rst has priority over every other input.

Verification (MEM_LATENCY=2, STARVE_LIMIT=4; t = IDLE sample cycle)
REQ-039 Fetch only: if_addr=0x00000004, mem_rdata=0x20020005 at t+3 -> mem_en=1 with mem_addr=0x4 at t+1; if_ready=1 with if_rdata=0x20020005 at t+4; stall=1 from t to t+3.
REQ-040 Simultaneous if_req and dm_req (load, 0x10) -> data served first with dm_ready at t+4; fetch mem_en at t+6; if_ready at t+9.
REQ-041 Store dm_addr=0x10, dm_wdata=0xDEADBEEF -> mem_en=mem_we=1 at t+1 only, with mem_wdata=0xDEADBEEF; dm_ready at t+4; dm_rdata unchanged.
REQ-042 Starvation: dm_req and if_req both held high continuously -> grant order DM, DM, DM, DM, IF, DM.
REQ-043 rst asserted at t+2 (in WAIT) -> IDLE with all outputs 0 at t+3; no ready pulse; next request restarts at the full latency.
REQ-044 Random back-to-back traffic -> each ready pulses exactly once per accepted request; never both readies in one cycle; mem_en never high in two consecutive cycles.
